gem_cluster_unpack: RTL and testbench
=====================================

# gem_cluster_unpack

Downstream stage of the GEM GTX optical receiver: accepts the 56-bit per-fiber GEM word and its link-quality flags in the `clock` domain, unpacks it into four 14-bit clusters, validates each cluster, and gates output with a link-qualification state machine. It also keeps saturating occupancy and error counters for VME readout. Its outputs feed the GEM cluster-to-strip mapping and GEM–CSC coincidence logic.

## Interface
- `HOLDOFF_BX`, 16: consecutive BX the link must be good before clusters are passed (1..255).
- `MAX_ADR`, 1535: highest legal cluster address.
- `clock`  in  1  40 MHz fabric clock; all logic on posedge.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `ttc_resync`  in  1  synchronous clear of counters and forced return to DOWN.
- `gem_data`  in  56  fiber word; cluster i = bits [14i+13:14i].
- `link_good`  in  1  link monitor good flag.
- `link_bad`  in  1  link monitor bad flag.
- `mask_link`  in  1  software kill; forces outputs masked.
- `cluster_vpf`  out  4  per-cluster valid.
- `cluster_adr`  out  44  4×11-bit addresses, cluster i at [11i+10:11i].
- `cluster_size`  out  12  4×3-bit sizes (cluster width − 1).
- `ncluster`  out  3  count of valid clusters this BX (0..4).
- `overflow`  out  1  all four slots valid this BX.
- `link_state`  out  2  DOWN=0, ARM=1, UP=2, LOST=3.
- `cluster_cnt`  out  16  saturating count of valid clusters passed.
- `bad_adr_cnt`  out  16  saturating count of clusters with address in (MAX_ADR, 0x7FE].
- `link_lost_cnt`  out  8  saturating count of UP→LOST transitions.

## Operation
- Cluster field: [10:0] address, [13:11] size. Address 0x7FF = empty slot (not an error). Address ≤ MAX_ADR = valid. Any other address = bad: slot reported invalid, `bad_adr_cnt` += 1 per bad slot.
- Bad addresses are counted in every state except DOWN. They are not counted when `mask_link` = 1.
- FSM, evaluated each posedge. Define `ok` = `link_good` & !`link_bad` & !`mask_link`.
  - DOWN: if `ok`, go to ARM and clear the holdoff counter.
  - ARM: if !`ok`, go to DOWN. Otherwise increment the counter; when counter = HOLDOFF_BX−1, go to UP.
  - UP: if !`ok`, go to LOST and increment `link_lost_cnt`.
  - LOST: go to DOWN unconditionally after one cycle.
- Outputs pass only in UP. In every other state, `cluster_vpf`, `cluster_adr`, `cluster_size`, `ncluster` and `overflow` are 0.
- `cluster_cnt` += `ncluster` each cycle in UP, saturating at 0xFFFF. Add-then-clamp: the sum uses 17 bits and the result is clamped to 0xFFFF.
- All counters saturate; they never wrap.
- `ttc_resync` clears all counters and the FSM goes to DOWN on the same edge. If `ttc_resync` and an increment occur together, the clear wins.
- `mask_link` = 1 in UP → LOST, and `link_lost_cnt` increments.

## Timing
- `gem_data` from the receiver changes on the falling edge of `clock`. This block samples it on the following posedge (stage 1 register).
- Decode and masking happen in stage 2.
- Latency: data sampled at posedge N appears on the outputs after posedge N+1, i.e. 2 posedges.
- `link_good`/`link_bad` are registered in stage 1 alongside the data. This keeps the FSM aligned with the word it gates.
- Counters update at stage 2, the same edge the outputs update.
- Reset values: all outputs 0; `link_state` = DOWN; holdoff counter 0.
- Reset asserted mid-operation clears everything immediately (asynchronously). After release, a full holdoff is required again.

## Structure
- Package `gem_pkg` contains:
  - `GEM_ADR_BITS` = 11, `GEM_SIZE_BITS` = 3, `GEM_NCLST` = 4
  - `GEM_NO_CLUSTER` = 11'h7FF
  - the `link_state` encodings DOWN/ARM/UP/LOST
- One sub-module, `gem_cluster_check`, instantiated 4× inside this block.
  - Purely combinational.
  - Input: 14-bit cluster.
  - Outputs: `vpf`, `bad`, `adr`, `size`.
- FSM, counters and pipeline registers live in the top of this block.

## Test plan
- **Qualification:** `link_good`=1 and `link_bad`=0 held.
  - `link_state` goes 0→1 one edge after sampling, and reaches 2 after 16 more edges.
  - No cluster appears before UP.
- **Unpack:** in UP, drive `gem_data` with cluster0 = adr 5 / size 2, cluster1 = 0x7FF, cluster2 = adr 1535 / size 7, cluster3 = 0x7FF.
  - Two edges later: `cluster_vpf` = 4'b0101, `ncluster` = 2, `overflow` = 0.
  - `cluster_cnt` increments by 2.
- **Bad address:** all four slots = adr 1600.
  - `cluster_vpf` = 0 and `bad_adr_cnt` += 4 per BX.
  - Repeated over 20000 BX, `bad_adr_cnt` sticks at 0xFFFF.
- **Link loss:** in UP, drop `link_good` for one cycle.
  - State sequence UP→LOST→DOWN.
  - `link_lost_cnt` = 1.
  - Outputs are zero from the LOST edge onward.
  - Re-qualification takes HOLDOFF_BX cycles.
- **Resync collision:** assert `ttc_resync` on the same cycle as a 4-cluster word in UP.
  - All counters read 0 and the state is DOWN.
  - `overflow` stays 0.
- **Reset:** drop `reset_n` in UP with counters nonzero.
  - All outputs read 0 immediately, without waiting for a clock edge.
  - After release, the state is DOWN.

Source files
------------

// File: rtl/gem_cluster_unpack_pkg.sv
// Shared definitions for the GEM cluster unpacker.
// Field widths, the empty-slot marker, the link-qualification state
// encodings and a small population-count helper.
package gem_pkg;
  localparam int GEM_ADR_BITS  = 11;
  localparam int GEM_SIZE_BITS = 3;
  localparam int GEM_NCLST     = 4;
  localparam int GEM_CL_BITS   = GEM_ADR_BITS + GEM_SIZE_BITS;

  localparam logic [GEM_ADR_BITS-1:0] GEM_NO_CLUSTER = 11'h7FF;

  typedef enum logic [1:0] {
    DOWN = 2'd0,
    ARM  = 2'd1,
    UP   = 2'd2,
    LOST = 2'd3
  } link_state_t;

  // Number of set bits in a per-slot flag vector (0..4).
  function automatic logic [2:0] count4(input logic [GEM_NCLST-1:0] v);
    count4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction
endpackage

// File: rtl/gem_cluster_unpack_if.sv
// Bus between the optical receiver / VME side and the cluster unpacker.
// master: receiver side (drives fiber word, link flags, resync, mask;
//         reads clusters, state and counters).
// slave : the unpacker itself.
interface gem_cluster_unpack_if;
  import gem_pkg::*;

  logic                                           ttc_resync;
  logic [GEM_NCLST-1:0][GEM_CL_BITS-1:0]          gem_data;
  logic                                           link_good;
  logic                                           link_bad;
  logic                                           mask_link;

  logic [GEM_NCLST-1:0]                           cluster_vpf;
  logic [GEM_NCLST-1:0][GEM_ADR_BITS-1:0]         cluster_adr;
  logic [GEM_NCLST-1:0][GEM_SIZE_BITS-1:0]        cluster_size;
  logic [2:0]                                     ncluster;
  logic                                           overflow;
  logic [1:0]                                     link_state;
  logic [15:0]                                    cluster_cnt;
  logic [15:0]                                    bad_adr_cnt;
  logic [7:0]                                     link_lost_cnt;

  modport master (
    output ttc_resync, gem_data, link_good, link_bad, mask_link,
    input  cluster_vpf, cluster_adr, cluster_size, ncluster, overflow,
           link_state, cluster_cnt, bad_adr_cnt, link_lost_cnt
  );

  modport slave (
    input  ttc_resync, gem_data, link_good, link_bad, mask_link,
    output cluster_vpf, cluster_adr, cluster_size, ncluster, overflow,
           link_state, cluster_cnt, bad_adr_cnt, link_lost_cnt
  );
endinterface

// File: rtl/gem_cluster_unpack_check.sv
// Combinational check of one 14-bit cluster field.
//   cluster : [10:0] address, [13:11] size
//   vpf     : address is legal (<= MAX_ADR)
//   bad     : address is neither legal nor the empty marker
//   adr/size: raw fields, gated downstream
module gem_cluster_check
  import gem_pkg::*;
#(
  parameter int MAX_ADR = 1535
) (
  input  logic [GEM_CL_BITS-1:0]   cluster,
  output logic                     vpf,
  output logic                     bad,
  output logic [GEM_ADR_BITS-1:0]  adr,
  output logic [GEM_SIZE_BITS-1:0] size
);
  localparam logic [GEM_ADR_BITS-1:0] MAX_A = GEM_ADR_BITS'(MAX_ADR);

  logic empty;

  assign adr   = cluster[GEM_ADR_BITS-1:0];
  assign size  = cluster[GEM_CL_BITS-1:GEM_ADR_BITS];
  assign empty = (adr == GEM_NO_CLUSTER);
  assign vpf   = !empty && (adr <= MAX_A);
  assign bad   = !empty && (adr >  MAX_A);
endmodule

// File: rtl/gem_cluster_unpack.sv
// GEM per-fiber cluster unpacker.
// Stage 1 registers the fiber word and link flags; stage 2 decodes the
// four clusters, gates them with the link-qualification FSM and updates
// the saturating occupancy/error counters.
// Ports:
//   clock, reset_n : fabric clock, async active-low reset
//   bus (slave)    : fiber word, link flags, resync/mask in;
//                    clusters, link state and counters out
module gem_cluster_unpack
  import gem_pkg::*;
#(
  parameter int HOLDOFF_BX = 16,
  parameter int MAX_ADR    = 1535
) (
  input  logic                 clock,
  input  logic                 reset_n,
  gem_cluster_unpack_if.slave  bus
);
  // ---------------- stage 1 ----------------
  logic [GEM_NCLST-1:0][GEM_CL_BITS-1:0] data_q;
  logic                                  good_q, bad_q, mask_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= '0;
      good_q <= 1'b0;
      bad_q  <= 1'b0;
      mask_q <= 1'b0;
    end else begin
      data_q <= bus.gem_data;
      good_q <= bus.link_good;
      bad_q  <= bus.link_bad;
      mask_q <= bus.mask_link;
    end
  end

  // ---------------- per-cluster check ----------------
  logic [GEM_NCLST-1:0]                    vpf_c, bad_c;
  logic [GEM_NCLST-1:0][GEM_ADR_BITS-1:0]  adr_c;
  logic [GEM_NCLST-1:0][GEM_SIZE_BITS-1:0] size_c;

  for (genvar i = 0; i < GEM_NCLST; i++) begin : g_chk
    gem_cluster_check #(.MAX_ADR(MAX_ADR)) u_chk (
      .cluster (data_q[i]),
      .vpf     (vpf_c[i]),
      .bad     (bad_c[i]),
      .adr     (adr_c[i]),
      .size    (size_c[i])
    );
  end

  // ---------------- link qualification FSM ----------------
  link_state_t state, state_n;
  logic [7:0]  hold, hold_n;
  logic        lost_inc;
  logic        ok;

  assign ok = good_q & ~bad_q & ~mask_q;

  always_comb begin
    state_n  = state;
    hold_n   = hold;
    lost_inc = 1'b0;
    case (state)
      DOWN: if (ok) begin
        state_n = ARM;
        hold_n  = 8'd0;
      end
      ARM: begin
        if (!ok)                              state_n = DOWN;
        else if (hold == 8'(HOLDOFF_BX - 1))  state_n = UP;
        else                                  hold_n  = hold + 8'd1;
      end
      UP: if (!ok) begin
        state_n  = LOST;
        lost_inc = 1'b1;
      end
      LOST:    state_n = DOWN;
      default: state_n = DOWN;
    endcase
    // Resync overrides whatever the link did this cycle.
    if (bus.ttc_resync) begin
      state_n  = DOWN;
      hold_n   = 8'd0;
      lost_inc = 1'b0;
    end
  end

  // ---------------- stage 2 decode ----------------
  // Gating uses the state being entered on this edge, so the word that
  // arrives with a bad link flag is already suppressed on the LOST edge.
  logic [GEM_NCLST-1:0]                    vpf_d;
  logic [GEM_NCLST-1:0][GEM_ADR_BITS-1:0]  adr_d;
  logic [GEM_NCLST-1:0][GEM_SIZE_BITS-1:0] size_d;
  logic [2:0]                              ncl_d, nbad_d;
  logic [16:0]                             cnt_sum, bad_sum;
  logic [15:0]                             cnt_d, badcnt_d;
  logic [7:0]                              lost_d;

  logic [GEM_NCLST-1:0]                    vpf_q;
  logic [GEM_NCLST-1:0][GEM_ADR_BITS-1:0]  adr_q;
  logic [GEM_NCLST-1:0][GEM_SIZE_BITS-1:0] size_q;
  logic [2:0]                              ncl_q;
  logic                                    ovf_q;
  logic [15:0]                             cnt_q, badcnt_q;
  logic [7:0]                              lost_q;

  always_comb begin
    vpf_d  = '0;
    adr_d  = '0;
    size_d = '0;
    for (int i = 0; i < GEM_NCLST; i++) begin
      if (state_n == UP && vpf_c[i]) begin
        vpf_d[i]  = 1'b1;
        adr_d[i]  = adr_c[i];
        size_d[i] = size_c[i];
      end
    end
    ncl_d  = count4(vpf_d);
    // Bad addresses count whenever the link is out of DOWN and not masked.
    nbad_d = (state != DOWN && !mask_q) ? count4(bad_c) : 3'd0;

    cnt_sum  = {1'b0, cnt_q}    + 17'(ncl_d);
    bad_sum  = {1'b0, badcnt_q} + 17'(nbad_d);
    cnt_d    = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    badcnt_d = bad_sum[16] ? 16'hFFFF : bad_sum[15:0];
    lost_d   = (lost_inc && lost_q != 8'hFF) ? lost_q + 8'd1 : lost_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= DOWN;
      hold     <= 8'd0;
      vpf_q    <= '0;
      adr_q    <= '0;
      size_q   <= '0;
      ncl_q    <= 3'd0;
      ovf_q    <= 1'b0;
      cnt_q    <= 16'd0;
      badcnt_q <= 16'd0;
      lost_q   <= 8'd0;
    end else begin
      state  <= state_n;
      hold   <= hold_n;
      vpf_q  <= vpf_d;
      adr_q  <= adr_d;
      size_q <= size_d;
      ncl_q  <= ncl_d;
      ovf_q  <= &vpf_d;
      if (bus.ttc_resync) begin
        cnt_q    <= 16'd0;
        badcnt_q <= 16'd0;
        lost_q   <= 8'd0;
      end else begin
        cnt_q    <= cnt_d;
        badcnt_q <= badcnt_d;
        lost_q   <= lost_d;
      end
    end
  end

  assign bus.cluster_vpf   = vpf_q;
  assign bus.cluster_adr   = adr_q;
  assign bus.cluster_size  = size_q;
  assign bus.ncluster      = ncl_q;
  assign bus.overflow      = ovf_q;
  assign bus.link_state    = state;
  assign bus.cluster_cnt   = cnt_q;
  assign bus.bad_adr_cnt   = badcnt_q;
  assign bus.link_lost_cnt = lost_q;
endmodule

// File: tb/tb_gem_cluster_unpack.sv
// Directed bench for gem_cluster_unpack: qualification, unpack, bad
// address saturation, link loss, mask, resync collision and async reset.
module tb_gem_cluster_unpack;
  localparam logic [13:0] E        = {3'd0, 11'h7FF};
  localparam logic [55:0] W_EMPTY  = {E, E, E, E};
  localparam logic [55:0] W_UNPACK = {E, {3'd7, 11'd1535}, E, {3'd2, 11'd5}};
  localparam logic [55:0] W_FULL   = {{3'd1, 11'd1535}, {3'd1, 11'd100},
                                      {3'd1, 11'd1},    {3'd1, 11'd0}};
  localparam logic [55:0] W_BAD    = {{3'd0, 11'd1600}, {3'd0, 11'd1600},
                                      {3'd0, 11'd1600}, {3'd0, 11'd1600}};
  localparam logic [43:0] ADR_UNPACK  = {11'd0, 11'd1535, 11'd0, 11'd5};
  localparam logic [11:0] SIZE_UNPACK = {3'd0, 3'd7, 3'd0, 3'd2};

  logic clock = 1'b0;
  logic reset_n;
  int   total = 0;
  int   fails = 0;

  gem_cluster_unpack_if bus();

  gem_cluster_unpack #(.HOLDOFF_BX(16), .MAX_ADR(1535)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Tick until UP, bounded; an expired bound is a failure.
  task automatic wait_up();
    int n = 0;
    while (bus.link_state !== 2'd2 && n < 40) begin
      tick();
      n++;
    end
    total++;
    if (bus.link_state !== 2'd2) begin fails++; $display("FAIL wait_up state got=%0d exp=2", bus.link_state); end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.ttc_resync = 1'b0; bus.gem_data = W_EMPTY;
    bus.link_good = 1'b0;  bus.link_bad = 1'b0; bus.mask_link = 1'b0;
    repeat (2) tick();
    total++;
    if (bus.link_state !== 2'd0 || bus.cluster_vpf !== 4'd0 || bus.ncluster !== 3'd0 || bus.overflow !== 1'b0) begin
      fails++; $display("FAIL reset_out state=%0d vpf=%b ncl=%0d ovf=%b exp all 0", bus.link_state, bus.cluster_vpf, bus.ncluster, bus.overflow);
    end
    total++;
    if (bus.cluster_cnt !== 16'd0 || bus.bad_adr_cnt !== 16'd0 || bus.link_lost_cnt !== 8'd0) begin
      fails++; $display("FAIL reset_cnt cnt=%0h bad=%0h lost=%0h exp 0", bus.cluster_cnt, bus.bad_adr_cnt, bus.link_lost_cnt);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_qualify();
    bus.gem_data = W_UNPACK;
    bus.link_good = 1'b1;
    tick();
    total++;
    if (bus.link_state !== 2'd0) begin fails++; $display("FAIL qual_sample state got=%0d exp=0", bus.link_state); end
    tick();
    total++;
    if (bus.link_state !== 2'd1) begin fails++; $display("FAIL qual_arm state got=%0d exp=1", bus.link_state); end
    for (int i = 0; i < 15; i++) begin
      tick();
      total++;
      if (bus.link_state !== 2'd1 || bus.cluster_vpf !== 4'd0 || bus.ncluster !== 3'd0 || bus.cluster_cnt !== 16'd0) begin
        fails++; $display("FAIL qual_hold[%0d] state=%0d vpf=%b ncl=%0d cnt=%0d exp 1/0/0/0", i, bus.link_state, bus.cluster_vpf, bus.ncluster, bus.cluster_cnt);
      end
    end
    bus.gem_data = W_EMPTY;
    tick();
    total++;
    if (bus.link_state !== 2'd2) begin fails++; $display("FAIL qual_up state got=%0d exp=2", bus.link_state); end
    total++;
    if (bus.cluster_vpf !== 4'b0101 || bus.cluster_cnt !== 16'd2) begin
      fails++; $display("FAIL qual_first vpf=%b cnt=%0d exp 0101/2", bus.cluster_vpf, bus.cluster_cnt);
    end
    tick();
    total++;
    if (bus.cluster_vpf !== 4'd0 || bus.cluster_cnt !== 16'd2) begin
      fails++; $display("FAIL qual_flush vpf=%b cnt=%0d exp 0/2", bus.cluster_vpf, bus.cluster_cnt);
    end
  endtask

  task automatic test_unpack();
    bus.gem_data = W_UNPACK;
    tick();
    total++;
    if (bus.cluster_vpf !== 4'd0) begin fails++; $display("FAIL unpack_lat vpf got=%b exp=0000", bus.cluster_vpf); end
    bus.gem_data = W_EMPTY;
    tick();
    total++;
    if (bus.cluster_vpf !== 4'b0101 || bus.ncluster !== 3'd2 || bus.overflow !== 1'b0) begin
      fails++; $display("FAIL unpack_vpf vpf=%b ncl=%0d ovf=%b exp 0101/2/0", bus.cluster_vpf, bus.ncluster, bus.overflow);
    end
    total++;
    if (bus.cluster_adr !== ADR_UNPACK || bus.cluster_size !== SIZE_UNPACK) begin
      fails++; $display("FAIL unpack_fields adr=%h size=%h exp %h/%h", bus.cluster_adr, bus.cluster_size, ADR_UNPACK, SIZE_UNPACK);
    end
    total++;
    if (bus.cluster_cnt !== 16'd4) begin fails++; $display("FAIL unpack_cnt got=%0d exp=4", bus.cluster_cnt); end
    bus.gem_data = W_FULL;
    tick();
    bus.gem_data = W_EMPTY;
    tick();
    total++;
    if (bus.cluster_vpf !== 4'hF || bus.ncluster !== 3'd4 || bus.overflow !== 1'b1 || bus.cluster_cnt !== 16'd8) begin
      fails++; $display("FAIL unpack_full vpf=%b ncl=%0d ovf=%b cnt=%0d exp 1111/4/1/8", bus.cluster_vpf, bus.ncluster, bus.overflow, bus.cluster_cnt);
    end
    tick();
    total++;
    if (bus.overflow !== 1'b0 || bus.ncluster !== 3'd0) begin
      fails++; $display("FAIL unpack_empty ovf=%b ncl=%0d exp 0/0", bus.overflow, bus.ncluster);
    end
  endtask

  task automatic test_bad_adr();
    bus.gem_data = W_BAD;
    tick();
    tick();
    total++;
    if (bus.cluster_vpf !== 4'd0 || bus.bad_adr_cnt !== 16'd4 || bus.cluster_cnt !== 16'd8) begin
      fails++; $display("FAIL bad_first vpf=%b bad=%0d cnt=%0d exp 0/4/8", bus.cluster_vpf, bus.bad_adr_cnt, bus.cluster_cnt);
    end
    tick();
    total++;
    if (bus.bad_adr_cnt !== 16'd8) begin fails++; $display("FAIL bad_second got=%0d exp=8", bus.bad_adr_cnt); end
    repeat (20000) tick();
    total++;
    if (bus.bad_adr_cnt !== 16'hFFFF) begin fails++; $display("FAIL bad_sat got=%0h exp=ffff", bus.bad_adr_cnt); end
    total++;
    if (bus.link_state !== 2'd2 || bus.cluster_cnt !== 16'd8) begin
      fails++; $display("FAIL bad_state state=%0d cnt=%0d exp 2/8", bus.link_state, bus.cluster_cnt);
    end
    bus.gem_data = W_EMPTY;
    repeat (2) tick();
  endtask

  task automatic test_link_loss();
    bus.gem_data = W_UNPACK;
    tick();
    tick();
    total++;
    if (bus.cluster_vpf !== 4'b0101 || bus.cluster_cnt !== 16'd10) begin
      fails++; $display("FAIL loss_pre vpf=%b cnt=%0d exp 0101/10", bus.cluster_vpf, bus.cluster_cnt);
    end
    bus.link_good = 1'b0;
    tick();
    total++;
    if (bus.link_state !== 2'd2 || bus.cluster_cnt !== 16'd12) begin
      fails++; $display("FAIL loss_sample state=%0d cnt=%0d exp 2/12", bus.link_state, bus.cluster_cnt);
    end
    bus.link_good = 1'b1;
    tick();
    total++;
    if (bus.link_state !== 2'd3 || bus.link_lost_cnt !== 8'd1) begin
      fails++; $display("FAIL loss_lost state=%0d lost=%0d exp 3/1", bus.link_state, bus.link_lost_cnt);
    end
    total++;
    if (bus.cluster_vpf !== 4'd0 || bus.ncluster !== 3'd0 || bus.cluster_adr !== 44'd0 || bus.cluster_cnt !== 16'd12) begin
      fails++; $display("FAIL loss_gate vpf=%b ncl=%0d adr=%h cnt=%0d exp 0/0/0/12", bus.cluster_vpf, bus.ncluster, bus.cluster_adr, bus.cluster_cnt);
    end
    tick();
    total++;
    if (bus.link_state !== 2'd0 || bus.cluster_vpf !== 4'd0) begin
      fails++; $display("FAIL loss_down state=%0d vpf=%b exp 0/0", bus.link_state, bus.cluster_vpf);
    end
    tick();
    total++;
    if (bus.link_state !== 2'd1) begin fails++; $display("FAIL loss_rearm state got=%0d exp=1", bus.link_state); end
    for (int i = 0; i < 15; i++) begin
      tick();
      total++;
      if (bus.link_state !== 2'd1 || bus.cluster_vpf !== 4'd0) begin
        fails++; $display("FAIL loss_hold[%0d] state=%0d vpf=%b exp 1/0", i, bus.link_state, bus.cluster_vpf);
      end
    end
    tick();
    total++;
    if (bus.link_state !== 2'd2 || bus.cluster_vpf !== 4'b0101 || bus.cluster_cnt !== 16'd14) begin
      fails++; $display("FAIL loss_requal state=%0d vpf=%b cnt=%0d exp 2/0101/14", bus.link_state, bus.cluster_vpf, bus.cluster_cnt);
    end
    bus.gem_data = W_EMPTY;
    tick();
    tick();
    total++;
    if (bus.cluster_cnt !== 16'd16) begin fails++; $display("FAIL loss_cnt got=%0d exp=16", bus.cluster_cnt); end
  endtask

  task automatic test_mask();
    bus.mask_link = 1'b1;
    tick();
    total++;
    if (bus.link_state !== 2'd2) begin fails++; $display("FAIL mask_sample state got=%0d exp=2", bus.link_state); end
    tick();
    total++;
    if (bus.link_state !== 2'd3 || bus.link_lost_cnt !== 8'd2) begin
      fails++; $display("FAIL mask_lost state=%0d lost=%0d exp 3/2", bus.link_state, bus.link_lost_cnt);
    end
    bus.mask_link = 1'b0;
    tick();
    total++;
    if (bus.link_state !== 2'd0) begin fails++; $display("FAIL mask_down state got=%0d exp=0", bus.link_state); end
    wait_up();
  endtask

  task automatic test_resync();
    bus.gem_data = W_FULL;
    tick();
    bus.ttc_resync = 1'b1;
    bus.gem_data = W_EMPTY;
    tick();
    total++;
    if (bus.link_state !== 2'd0 || bus.overflow !== 1'b0 || bus.ncluster !== 3'd0) begin
      fails++; $display("FAIL resync_gate state=%0d ovf=%b ncl=%0d exp 0/0/0", bus.link_state, bus.overflow, bus.ncluster);
    end
    total++;
    if (bus.cluster_cnt !== 16'd0 || bus.bad_adr_cnt !== 16'd0 || bus.link_lost_cnt !== 8'd0) begin
      fails++; $display("FAIL resync_cnt cnt=%0h bad=%0h lost=%0h exp 0", bus.cluster_cnt, bus.bad_adr_cnt, bus.link_lost_cnt);
    end
    bus.ttc_resync = 1'b0;
    tick();
    total++;
    if (bus.link_state !== 2'd1 || bus.overflow !== 1'b0 || bus.cluster_cnt !== 16'd0) begin
      fails++; $display("FAIL resync_after state=%0d ovf=%b cnt=%0d exp 1/0/0", bus.link_state, bus.overflow, bus.cluster_cnt);
    end
    wait_up();
  endtask

  task automatic test_async_reset();
    bus.gem_data = W_UNPACK;
    tick();
    bus.gem_data = W_EMPTY;
    tick();
    total++;
    if (bus.cluster_vpf !== 4'b0101 || bus.cluster_cnt !== 16'd2) begin
      fails++; $display("FAIL arst_pre vpf=%b cnt=%0d exp 0101/2", bus.cluster_vpf, bus.cluster_cnt);
    end
    #2 reset_n = 1'b0;
    #1;
    total++;
    if (bus.cluster_vpf !== 4'd0 || bus.cluster_adr !== 44'd0 || bus.cluster_size !== 12'd0 || bus.link_state !== 2'd0) begin
      fails++; $display("FAIL arst_out vpf=%b adr=%h size=%h state=%0d exp 0", bus.cluster_vpf, bus.cluster_adr, bus.cluster_size, bus.link_state);
    end
    total++;
    if (bus.cluster_cnt !== 16'd0 || bus.ncluster !== 3'd0) begin
      fails++; $display("FAIL arst_cnt cnt=%0d ncl=%0d exp 0/0", bus.cluster_cnt, bus.ncluster);
    end
    #2 reset_n = 1'b1;
    tick();
    total++;
    if (bus.link_state !== 2'd0) begin fails++; $display("FAIL arst_release state got=%0d exp=0", bus.link_state); end
    tick();
    total++;
    if (bus.link_state !== 2'd1) begin fails++; $display("FAIL arst_rearm state got=%0d exp=1", bus.link_state); end
  endtask

  initial begin
    test_reset();
    test_qualify();
    test_unpack();
    test_bad_adr();
    test_link_loss();
    test_mask();
    test_resync();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, fails);
    $finish;
  end
endmodule
